// File: rtl/sd_spi_bus_arbiter_if.sv
// rtl/sd_spi_bus_arbiter_if.sv - requester/pad bundle for the SD SPI bus arbiter
interface sd_spi_bus_arbiter_if #(
    parameter int N_REQ = 2
);
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] cs_i;
    logic [N_REQ-1:0] sclk_i;
    logic [N_REQ-1:0] mosi_i;
    logic             cs;
    logic             sclk;
    logic             mosi;
    logic [OW-1:0]    owner;
    logic             busy;
    logic             timeout_err;

    // requester side: raises req and drives its own SPI pins
    modport master (
        output req, cs_i, sclk_i, mosi_i,
        input  gnt, cs, sclk, mosi, owner, busy, timeout_err
    );

    // arbiter side: grants and drives the shared SD pads
    modport slave (
        input  req, cs_i, sclk_i, mosi_i,
        output gnt, cs, sclk, mosi, owner, busy, timeout_err
    );
endinterface

// File: rtl/sd_spi_bus_arbiter.sv
// rtl/sd_spi_bus_arbiter.sv - round-robin SD SPI bus arbiter with guard gap (optional ARB_TIMEOUT_EN watchdog)
module sd_spi_bus_arbiter #(
    parameter int          N_REQ        = 2,
    parameter int          GUARD_CYCLES = 8,
    parameter int unsigned TIMEOUT_CYC  = 2**24
) (
    input logic                 clk,
    input logic                 rst,
    sd_spi_bus_arbiter_if.slave bus
);
    localparam int OW = $clog2(N_REQ);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;
    // with no guard gap a released bus goes straight back to arbitration
    localparam logic [1:0] S_AFTER = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic [1:0]       state;
    logic [GW-1:0]    guard_cnt;
    logic [31:0]      to_cnt;
    logic [N_REQ-1:0] blocked;
    logic [N_REQ-1:0] eligible;
    logic [OW-1:0]    winner;
    logic             release_now;
    logic             timeout_hit;

    // a requester revoked by the watchdog stays out until it drops req
    always_comb eligible = bus.req & ~blocked;

    // round-robin pick: first eligible bit from owner+1 upward, wrapping
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = int'(bus.owner) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (eligible[OW'(idx)]) winner = OW'(idx);
        end
    end

    // owner lets go only when it has dropped req and its transaction is closed
    always_comb begin
        release_now = !bus.req[bus.owner] && bus.cs_i[bus.owner];
        timeout_hit = TO_EN && (to_cnt == TIMEOUT_CYC - 32'd1);
    end

    assign bus.busy = (state != S_IDLE);

    // arbitration FSM, registered grant and registered pad mux
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            bus.gnt         <= '0;
            bus.cs          <= 1'b1;
            bus.sclk        <= 1'b0;
            bus.mosi        <= 1'b1;
            bus.owner       <= OW'(N_REQ - 1);
            bus.timeout_err <= 1'b0;
            guard_cnt       <= '0;
            to_cnt          <= '0;
            blocked         <= '0;
        end else begin
            bus.cs   <= 1'b1;
            bus.sclk <= 1'b0;
            bus.mosi <= 1'b1;
            if (TO_EN) blocked <= blocked & bus.req;
            case (state)
                S_IDLE: begin
                    if (|eligible) begin
                        bus.gnt         <= '0;
                        bus.gnt[winner] <= 1'b1;
                        bus.owner       <= winner;
                        to_cnt          <= '0;
                        state           <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (timeout_hit) begin
                        bus.gnt            <= '0;
                        bus.timeout_err    <= 1'b1;
                        blocked[bus.owner] <= 1'b1;
                        guard_cnt          <= '0;
                        state              <= S_AFTER;
                    end else if (release_now) begin
                        bus.gnt   <= '0;
                        guard_cnt <= '0;
                        state     <= S_AFTER;
                    end else begin
                        bus.cs   <= bus.cs_i[bus.owner];
                        bus.sclk <= bus.sclk_i[bus.owner];
                        bus.mosi <= bus.mosi_i[bus.owner];
                        if (TO_EN) to_cnt <= to_cnt + 32'd1;
                    end
                end
                S_GUARD: begin
                    if (guard_cnt == GW'(GUARD_CYCLES - 1)) state <= S_IDLE;
                    else guard_cnt <= guard_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_spi_bus_arbiter.sv
// tb/tb_sd_spi_bus_arbiter.sv - directed self-checking bench for sd_spi_bus_arbiter
module tb_sd_spi_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   waits;

    sd_spi_bus_arbiter_if #(.N_REQ(2)) bus ();

    sd_spi_bus_arbiter #(
        .N_REQ(2),
        .GUARD_CYCLES(8),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.req    = 2'b00;
        bus.cs_i   = 2'b11;
        bus.sclk_i = 2'b00;
        bus.mosi_i = 2'b11;
        step;
        step;
        check("rst_gnt",   32'(bus.gnt), 32'h0);
        check("rst_cs",    32'(bus.cs), 32'h1);
        check("rst_sclk",  32'(bus.sclk), 32'h0);
        check("rst_mosi",  32'(bus.mosi), 32'h1);
        check("rst_busy",  32'(bus.busy), 32'h0);
        check("rst_owner", 32'(bus.owner), 32'h1);
        check("rst_terr",  32'(bus.timeout_err), 32'h0);

        rst     = 1'b0;
        bus.req = 2'b11;
        step;
        check("first_gnt",   32'(bus.gnt), 32'h1);
        check("first_owner", 32'(bus.owner), 32'h0);
        check("first_busy",  32'(bus.busy), 32'h1);
        check("first_cs",    32'(bus.cs), 32'h1);

        bus.cs_i[0]   = 1'b0;
        bus.sclk_i[0] = 1'b1;
        bus.mosi_i[0] = 1'b0;
        check("pt_latency_cs", 32'(bus.cs), 32'h1);
        step;
        check("pt_cs0",   32'(bus.cs), 32'h0);
        check("pt_sclk1", 32'(bus.sclk), 32'h1);
        check("pt_mosi0", 32'(bus.mosi), 32'h0);
        bus.sclk_i[0] = 1'b0;
        bus.mosi_i[0] = 1'b1;
        step;
        check("pt_sclk0", 32'(bus.sclk), 32'h0);
        check("pt_mosi1", 32'(bus.mosi), 32'h1);
        bus.sclk_i[1] = 1'b1;
        bus.mosi_i[1] = 1'b0;
        bus.cs_i[1]   = 1'b0;
        step;
        check("nonowner_sclk", 32'(bus.sclk), 32'h0);
        check("nonowner_mosi", 32'(bus.mosi), 32'h1);
        check("nonowner_cs",   32'(bus.cs), 32'h0);
        bus.cs_i[1]   = 1'b1;
        bus.sclk_i[1] = 1'b0;
        bus.mosi_i[1] = 1'b1;

        bus.req[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step;
            check("nocut_gnt", 32'(bus.gnt), 32'h1);
        end
        check("nocut_cs", 32'(bus.cs), 32'h0);

        bus.cs_i[0] = 1'b1;
        step;
        check("release_gnt",   32'(bus.gnt), 32'h0);
        check("release_busy",  32'(bus.busy), 32'h1);
        check("release_cs",    32'(bus.cs), 32'h1);
        check("release_owner", 32'(bus.owner), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            step;
            check("guard_gnt", 32'(bus.gnt), 32'h0);
            check("guard_cs",  32'(bus.cs), 32'h1);
            if (i == 3) bus.req[0] = 1'b1;
        end
        step;
        check("rr_gnt1",   32'(bus.gnt), 32'h2);
        check("rr_owner1", 32'(bus.owner), 32'h1);

        bus.req[1] = 1'b0;
        step;
        check("rr_release1", 32'(bus.gnt), 32'h0);
        bus.req[1] = 1'b1;
        waits = 0;
        while (bus.gnt == 2'b00 && waits < 30) begin
            step;
            waits++;
        end
        check("rr_gap",    32'(waits), 32'd9);
        check("rr_gnt0",   32'(bus.gnt), 32'h1);
        check("rr_owner0", 32'(bus.owner), 32'h0);

        bus.cs_i[0] = 1'b0;
        step;
        check("arst_pre_cs", 32'(bus.cs), 32'h0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_cs",    32'(bus.cs), 32'h1);
        check("arst_gnt",   32'(bus.gnt), 32'h0);
        check("arst_busy",  32'(bus.busy), 32'h0);
        check("arst_owner", 32'(bus.owner), 32'h1);
        rst = 1'b0;
        step;
        check("arst_regnt",  32'(bus.gnt), 32'h1);
        check("arst_reown",  32'(bus.owner), 32'h0);

`ifdef ARB_TIMEOUT_EN
        waits = 0;
        while (bus.gnt != 2'b00 && waits < 200) begin
            step;
            waits++;
        end
        check("to_cycles", 32'(waits), 32'd100);
        check("to_err",    32'(bus.timeout_err), 32'h1);
        check("to_cs",     32'(bus.cs), 32'h1);
        waits = 0;
        while (bus.gnt == 2'b00 && waits < 30) begin
            step;
            waits++;
        end
        check("to_next_gap", 32'(waits), 32'd9);
        check("to_next_gnt", 32'(bus.gnt), 32'h2);
        check("to_sticky",   32'(bus.timeout_err), 32'h1);
`else
        repeat (120) step;
        check("hold_gnt",  32'(bus.gnt), 32'h1);
        check("hold_cs",   32'(bus.cs), 32'h0);
        check("hold_terr", 32'(bus.timeout_err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
